// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and shared memory port of the memory arbiter.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rdy;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_rdy;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdy, if_rvalid, if_rdata, d_rdy, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdy, if_rvalid, if_rdata, d_rdy, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter between a fetch port and a data port onto one memory.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 2
) (
    input logic clk,
    input logic rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  own_d;
    logic                  en_q;
    logic                  if_rv_q;
    logic                  d_rv_q;
    logic                  idle;
    logic                  grant_d;
    logic                  grant_if;

    assign idle = state == IDLE && !rst;
`ifdef ARB_RR_EN
    logic last_d;
    assign grant_d = idle && bus.d_req && (!bus.if_req || !last_d);
`else
    assign grant_d = idle && bus.d_req;
`endif
    assign grant_if = idle && bus.if_req && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            own_d   <= 1'b0;
            en_q    <= 1'b0;
            if_rv_q <= 1'b0;
            d_rv_q  <= 1'b0;
`ifdef ARB_RR_EN
            last_d  <= 1'b0;
`endif
        end else begin
            en_q    <= 1'b0;
            if_rv_q <= 1'b0;
            d_rv_q  <= 1'b0;
            case (state)
                IDLE: if (grant_d || grant_if) begin
                    state   <= ISSUE;
                    en_q    <= 1'b1;
                    addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                    wdata_q <= grant_d ? bus.d_wdata : '0;
                    we_q    <= grant_d && bus.d_we;
                    own_d   <= grant_d;
`ifdef ARB_RR_EN
                    last_d  <= grant_d;
`endif
                end
                ISSUE: if (we_q) begin
                    state <= IDLE;
                end else if (MEM_LAT == 1) begin
                    state   <= RESP;
                    if_rv_q <= !own_d;
                    d_rv_q  <= own_d;
                end else begin
                    state <= WAIT;
                    cnt   <= 4'(MEM_LAT - 1);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= RESP;
                        if_rv_q <= !own_d;
                        d_rv_q  <= own_d;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_rdy    = grant_if;
    assign bus.d_rdy     = grant_d;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = en_q && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rvalid = if_rv_q;
    assign bus.d_rvalid  = d_rv_q;
    // Read data is passed straight from memory during the response cycle only.
    assign bus.if_rdata  = if_rv_q ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rv_q ? bus.mem_rdata : '0;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, arbitration/reset sequences and a randomized run against a cycle-count model.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int L  = 2;
    localparam int N  = 800;
    localparam logic O = 1'b1;
    localparam logic Z = 1'b0;
    localparam logic [31:0] Z32 = 32'h0;

    typedef logic [134:0] vec_t;
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        vec_t        exp;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] env_mem [16];
    logic [31:0] hd [8];

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] init_val(int i);
        return i == 1 ? 32'h00500513 : 32'hA5000000 | 32'(i * 'h111);
    endfunction

    // Memory model: word-indexed store, read data delayed by the memory latency.
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        else if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        hd[0] <= env_mem[bus.mem_addr[5:2]];
        for (int i = 1; i < 8; i++) hd[i] <= hd[i-1];
    end
    assign bus.mem_rdata = hd[L-1];

    function automatic vec_t pack(logic ir, logic dr, logic en, logic we, logic [31:0] a, logic [31:0] wd,
                                  logic iv, logic [31:0] id, logic dv, logic [31:0] dd, logic b);
        return {ir, dr, en, we, en ? a : Z32, (en && we) ? wd : Z32, iv, id, dv, dd, b};
    endfunction

    function automatic vec_t act();
        return pack(bus.if_rdy, bus.d_rdy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata, bus.busy);
    endfunction

    task automatic chk(string name, vec_t got, vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(logic ir, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da, logic [31:0] dwd);
        bus.if_req = ir;
        bus.if_addr = ia;
        bus.d_req = dr;
        bus.d_we = dwe;
        bus.d_addr = da;
        bus.d_wdata = dwd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(Z, Z32, Z, Z, Z32, Z32);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic row_t mk(logic ir, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da,
                                logic [31:0] dwd, vec_t exp);
        row_t r;
        r.ir = ir; r.ia = ia; r.dr = dr; r.dwe = dwe; r.da = da; r.dwd = dwd; r.exp = exp;
        return r;
    endfunction

    row_t tbl [16];
    vec_t sched [N+16];
    logic [31:0] ref_mem [16];

    initial begin
        vec_t idle_v;
        idle_v = pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z);
        // Fetch read of 0x4, then a data write with a fetch queued behind it, then read-back.
        tbl[0]  = mk(O, 32'h4, Z, Z, Z32, Z32, pack(O, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        tbl[1]  = mk(Z, 32'h77, Z, Z, Z32, Z32, pack(Z, Z, O, Z, 32'h4, Z32, Z, Z32, Z, Z32, O));
        tbl[2]  = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, O));
        tbl[3]  = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, O, 32'h00500513, Z, Z32, O));
        tbl[4]  = mk(Z, Z32, Z, Z, Z32, Z32, idle_v);
        tbl[5]  = mk(Z, Z32, O, O, 32'h10, 32'hDEADBEEF, pack(Z, O, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        tbl[6]  = mk(O, 32'h8, Z, O, 32'h3C, 32'h1234, pack(Z, Z, O, O, 32'h10, 32'hDEADBEEF, Z, Z32, Z, Z32, O));
        tbl[7]  = mk(O, 32'h8, Z, Z, Z32, Z32, pack(O, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        tbl[8]  = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, O, Z, 32'h8, Z32, Z, Z32, Z, Z32, O));
        tbl[9]  = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, O));
        tbl[10] = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, O, init_val(2), Z, Z32, O));
        tbl[11] = mk(Z, Z32, O, Z, 32'h10, Z32, pack(Z, O, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        tbl[12] = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, O, Z, 32'h10, Z32, Z, Z32, Z, Z32, O));
        tbl[13] = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, O));
        tbl[14] = mk(Z, Z32, Z, Z, Z32, Z32, pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, O, 32'hDEADBEEF, O));
        tbl[15] = mk(Z, Z32, Z, Z, Z32, Z32, idle_v);

        do_reset();
        @(negedge clk) chk("reset", act(), idle_v);
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
            @(negedge clk) chk($sformatf("vec%0d", i), act(), tbl[i].exp);
            @(posedge clk); #1;
        end

        // Both ports hold read requests: grants every 4 cycles, pattern depends on arbitration mode.
        do_reset();
        drive(O, 32'h20, O, Z, 32'h30, Z32);
        for (int c = 1; c <= 16; c++) begin
            logic [1:0] e;
            logic dwin;
`ifdef ARB_RR_EN
            dwin = ((c - 1) / 4) % 2 == 0;
`else
            dwin = 1'b1;
`endif
            e = (c % 4 == 1) ? (dwin ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clk) chk($sformatf("arb_c%0d", c), vec_t'({bus.if_rdy, bus.d_rdy}), vec_t'(e));
            @(posedge clk); #1;
        end

        // Reset in the middle of a fetch read discards it.
        do_reset();
        drive(O, 32'h4, Z, Z, Z32, Z32);
        @(negedge clk) chk("rstmid_acc", act(), pack(O, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        @(posedge clk); #1 drive(Z, Z32, Z, Z, Z32, Z32);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drive(O, 32'h8, Z, Z, Z32, Z32);
        @(negedge clk) chk("rstmid_c4", act(), pack(O, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, Z));
        @(posedge clk); #1 drive(Z, Z32, Z, Z, Z32, Z32);
        @(negedge clk) chk("rstmid_c5", act(), pack(Z, Z, O, Z, 32'h8, Z32, Z, Z32, Z, Z32, O));
        @(posedge clk); #1;
        @(negedge clk) chk("rstmid_c6", act(), pack(Z, Z, Z, Z, Z32, Z32, Z, Z32, Z, Z32, O));
        @(posedge clk); #1;
        @(negedge clk) chk("rstmid_c7", act(), pack(Z, Z, Z, Z, Z32, Z32, O, init_val(2), Z, Z32, O));
        @(posedge clk); #1;
        @(negedge clk) chk("rstmid_c8", act(), idle_v);
        @(posedge clk); #1;

        // Randomized traffic against a cycle-arithmetic model of the arbiter.
        begin
            int free_at;
            logic last_d, ip, dp, dwe, gd, gi, b, we;
            logic [31:0] ia, da, dwd, a, data;
            free_at = 0; last_d = 1'b0; ip = 1'b0; dp = 1'b0;
            ia = Z32; da = Z32; dwd = Z32; dwe = 1'b0;
            for (int i = 0; i < N + 16; i++) sched[i] = '0;
            for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
            do_reset();
            for (int c = 0; c < N; c++) begin
                if (!ip) begin
                    ia = $urandom & 32'hFFFF_FFFC;
                    ip = $urandom_range(0, 1) == 1;
                end
                if (!dp) begin
                    da = $urandom & 32'hFFFF_FFFC;
                    dwe = $urandom_range(0, 1) == 1;
                    dwd = $urandom;
                    dp = $urandom_range(0, 2) != 0;
                end
                drive(ip, ia, dp, dwe, da, dwd);
                gd = 1'b0; gi = 1'b0;
                b = c < free_at;
                if (c >= free_at && (ip || dp)) begin
`ifdef ARB_RR_EN
                    gd = dp && (!ip || !last_d);
`else
                    gd = dp;
`endif
                    gi = !gd;
                    last_d = gd;
                    we = gd && dwe;
                    a = gd ? da : ia;
                    if (we) begin
                        sched[c+1] = sched[c+1] | pack(Z, Z, O, O, a, dwd, Z, Z32, Z, Z32, Z);
                        ref_mem[a[5:2]] = dwd;
                        free_at = c + 2;
                    end else begin
                        data = ref_mem[a[5:2]];
                        sched[c+1] = sched[c+1] | pack(Z, Z, O, Z, a, Z32, Z, Z32, Z, Z32, Z);
                        sched[c+1+L] = sched[c+1+L] | pack(Z, Z, Z, Z, Z32, Z32, gi, gi ? data : Z32,
                                                           gd, gd ? data : Z32, Z);
                        free_at = c + 2 + L;
                    end
                end
                @(negedge clk) chk($sformatf("rand%0d", c), act(),
                                   sched[c] | pack(gi, gd, Z, Z, Z32, Z32, Z, Z32, Z, Z32, b));
                if (gi) ip = 1'b0;
                if (gd) dp = 1'b0;
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
